uzorak_sekvencer: RTL and testbench

- Feeds the output neuron. Collects five 16-bit first-layer results arriving one per transfer on a valid/ready stream.
- Packs them into the neuron's 80-bit sample bus and holds that bus stable while the neuron's combinational datapath settles.
- Captures the neuron's 16-bit probability and returns it on a valid/ready result stream.
- Serialising producer and result consumer for the existing combinational neuron; one frame in flight at a time.

---
 rtl/uzorak_sekvencer_if.sv | 23 ++
 rtl/uzorak_sekvencer.sv | 110 +++++++++++
 tb/tb_uzorak_sekvencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uzorak_sekvencer_if.sv
// Valid/ready streams between the word producer, the sequencer and the result consumer.
// The sequencer sits on the slave side; producer/consumer logic uses the master side.
interface uzorak_sekvencer_if #(
    parameter int SIRINA = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [SIRINA-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [SIRINA-1:0] out_data;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/uzorak_sekvencer.sv
// Collects one framed set of words for the combinational output neuron, holds the packed
// sample while the neuron settles, then returns the captured probability on a result stream.
module uzorak_sekvencer #(
    parameter int BROJ_ULAZA = 5,
    parameter int SIRINA     = 16,
    parameter int SETTLE     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    uzorak_sekvencer_if.slave            bus,
    output logic [BROJ_ULAZA*SIRINA-1:0] uzorak,
    input  logic [SIRINA-1:0]            izlaz_neurona,
    output logic                         frame_err
);
    localparam int             IDX_W    = (BROJ_ULAZA > 1) ? $clog2(BROJ_ULAZA) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BROJ_ULAZA - 1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SETTLE,
        ST_RESULT
    } state_t;

    state_t                        state_reg;
    logic [IDX_W-1:0]              idx_reg;
    logic [3:0]                    cnt_reg;
    logic [SIRINA-1:0]             shadow_reg [BROJ_ULAZA];
    logic [BROJ_ULAZA*SIRINA-1:0]  uzorak_reg;
    logic [BROJ_ULAZA*SIRINA-1:0]  uzorak_next;
    logic [SIRINA-1:0]             out_data_reg;
    logic                          out_valid_reg;
    logic                          frame_err_reg;
    logic                          in_ready_int;
    logic                          accept;
    logic                          idx_at_last;

    assign in_ready_int = (state_reg == ST_COLLECT) && !rst;
    assign accept       = bus.in_valid && in_ready_int;
    assign idx_at_last  = (idx_reg == LAST_IDX);

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign uzorak        = uzorak_reg;
    assign frame_err     = frame_err_reg;

    // The closing word bypasses its shadow slot so the whole frame lands in uzorak at once.
    generate
        for (genvar gi = 0; gi < BROJ_ULAZA; gi++) begin : g_slot
            assign uzorak_next[gi*SIRINA +: SIRINA] =
                (idx_reg == IDX_W'(gi)) ? bus.in_data : shadow_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi] <= '0;
                end else if (accept && (idx_reg == IDX_W'(gi))) begin
                    shadow_reg[gi] <= bus.in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_COLLECT;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            uzorak_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            unique case (state_reg)
                ST_COLLECT: begin
                    if (accept) begin
                        if (idx_at_last && bus.in_last) begin
                            uzorak_reg <= uzorak_next;
                            idx_reg    <= '0;
                            cnt_reg    <= 4'(SETTLE - 1);
                            state_reg  <= ST_SETTLE;
                        end else if (!idx_at_last && !bus.in_last) begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end else begin
                            // Misframed: drop the partial frame, the neuron never sees it.
                            frame_err_reg <= 1'b1;
                            idx_reg       <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == 4'd0) begin
                        out_data_reg  <= izlaz_neurona;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_RESULT;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESULT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_COLLECT;
                    end
                end
                default: state_reg <= ST_COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_uzorak_sekvencer.sv
// Directed bench for uzorak_sekvencer: framing, settle latency, result back-pressure, reset.
module tb_uzorak_sekvencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] uzorak;
    logic [15:0] izlaz_neurona;
    logic        frame_err;

    int n_checks    = 0;
    int n_fail      = 0;
    int err_pulses  = 0;

    uzorak_sekvencer_if #(.SIRINA(16)) bus ();

    uzorak_sekvencer #(.BROJ_ULAZA(5), .SIRINA(16), .SETTLE(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .uzorak        (uzorak),
        .izlaz_neurona (izlaz_neurona),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle forward; every drive and check happens 1 ns after a falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last, input int gap);
        int k;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("send_ready", {79'd0, bus.in_ready}, 80'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic consume();
        int k;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("consume_valid", {79'd0, bus.out_valid}, 80'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        izlaz_neurona = 16'hABCD;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_uzorak", uzorak, 80'd0);
        chk("rst_out_valid", {79'd0, bus.out_valid}, 80'd0);
        chk("rst_out_data", {64'd0, bus.out_data}, 80'd0);
        chk("rst_in_ready", {79'd0, bus.in_ready}, 80'd1);
        chk("rst_frame_err", {79'd0, frame_err}, 80'd0);

        // 1: back-to-back frame, result after two settle cycles
        send(16'h1000, 1'b0, 0);
        send(16'h2000, 1'b0, 0);
        send(16'h3000, 1'b0, 0);
        send(16'h4000, 1'b0, 0);
        send(16'h5000, 1'b1, 0);
        chk("s1_uzorak", uzorak, 80'h5000_4000_3000_2000_1000);
        chk("s1_valid_N", {79'd0, bus.out_valid}, 80'd0);
        tick();
        chk("s1_valid_N1", {79'd0, bus.out_valid}, 80'd0);
        tick();
        chk("s1_valid_N2", {79'd0, bus.out_valid}, 80'd1);
        chk("s1_out_data", {64'd0, bus.out_data}, {64'd0, 16'hABCD});
        chk("s1_no_err", 80'(err_pulses), 80'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("s1_valid_drop", {79'd0, bus.out_valid}, 80'd0);
        chk("s1_ready_back", {79'd0, bus.in_ready}, 80'd1);
        chk("s1_data_kept", {64'd0, bus.out_data}, {64'd0, 16'hABCD});

        // 2: short frame then a correct one
        send(16'hAAAA, 1'b0, 0);
        send(16'hBBBB, 1'b0, 0);
        send(16'hCCCC, 1'b1, 0);
        chk("s2_err_hi", {79'd0, frame_err}, 80'd1);
        chk("s2_uzorak_kept", uzorak, 80'h5000_4000_3000_2000_1000);
        tick();
        chk("s2_err_lo", {79'd0, frame_err}, 80'd0);
        chk("s2_err_count", 80'(err_pulses), 80'd1);
        for (int i = 1; i <= 5; i++) send(16'(i), (i == 5), 0);
        chk("s2_uzorak", uzorak, 80'h0005_0004_0003_0002_0001);
        consume();

        // 3: five words without in_last
        for (int i = 0; i < 5; i++) send(16'h0F00 + 16'(i), 1'b0, 0);
        chk("s3_err_hi", {79'd0, frame_err}, 80'd1);
        chk("s3_uzorak_kept", uzorak, 80'h0005_0004_0003_0002_0001);
        tick();
        chk("s3_err_lo", {79'd0, frame_err}, 80'd0);
        tick();
        tick();
        chk("s3_no_valid", {79'd0, bus.out_valid}, 80'd0);
        chk("s3_ready", {79'd0, bus.in_ready}, 80'd1);

        // 4: result back-pressure while the neuron output and input stream wiggle
        izlaz_neurona = 16'h1111;
        for (int i = 1; i <= 5; i++) send(16'h0101 * 16'(i), (i == 5), 0);
        tick();
        tick();
        chk("s4_valid", {79'd0, bus.out_valid}, 80'd1);
        chk("s4_data", {64'd0, bus.out_data}, {64'd0, 16'h1111});
        for (int i = 0; i < 10; i++) begin
            izlaz_neurona = 16'($urandom);
            bus.in_valid  = 1'b1;
            bus.in_data   = 16'($urandom);
            bus.in_last   = 1'($urandom);
            #1;
            chk("s4_hold_ready", {79'd0, bus.in_ready}, 80'd0);
            chk("s4_hold_valid", {79'd0, bus.out_valid}, 80'd1);
            chk("s4_hold_data", {64'd0, bus.out_data}, {64'd0, 16'h1111});
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("s4_valid_drop", {79'd0, bus.out_valid}, 80'd0);
        chk("s4_ready_back", {79'd0, bus.in_ready}, 80'd1);
        chk("s4_uzorak", uzorak, 80'h0505_0404_0303_0202_0101);

        // 5: reset after two words, with a void offer during reset
        izlaz_neurona = 16'h5A5A;
        send(16'hEEEE, 1'b0, 0);
        send(16'hDDDD, 1'b0, 0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7777;
        #1;
        chk("s5_ready_in_rst", {79'd0, bus.in_ready}, 80'd0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("s5_uzorak", uzorak, 80'd0);
        chk("s5_out_data", {64'd0, bus.out_data}, 80'd0);
        chk("s5_out_valid", {79'd0, bus.out_valid}, 80'd0);
        chk("s5_in_ready", {79'd0, bus.in_ready}, 80'd1);
        for (int i = 0; i < 5; i++) send(16'h000A + 16'(i), (i == 4), 0);
        chk("s5_frame", uzorak, 80'h000E_000D_000C_000B_000A);
        tick();
        tick();
        chk("s5_result", {64'd0, bus.out_data}, {64'd0, 16'h5A5A});
        consume();

        // 6: scenario 1 words with random idle gaps
        izlaz_neurona = 16'hABCD;
        for (int i = 1; i <= 5; i++) send(16'h1000 * 16'(i), (i == 5), int'($urandom_range(0, 3)));
        chk("s6_uzorak", uzorak, 80'h5000_4000_3000_2000_1000);
        chk("s6_valid_N", {79'd0, bus.out_valid}, 80'd0);
        tick();
        chk("s6_valid_N1", {79'd0, bus.out_valid}, 80'd0);
        tick();
        chk("s6_valid_N2", {79'd0, bus.out_valid}, 80'd1);
        chk("s6_out_data", {64'd0, bus.out_data}, {64'd0, 16'hABCD});
        consume();
        chk("total_err_pulses", 80'(err_pulses), 80'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
